regfile_read_arbiter: RTL and testbench

- Shares the register file's two combinational read ports among NUM_REQ independent requesters, such as fetch/decode, a debug reader and a trace unit.
- Each cycle it grants up to two pending requests in round-robin order and drives the two 5-bit read selects.
- It captures the two 64-bit read data words and returns each word to its requester one cycle later on a per-requester response channel.

---
 rtl/regfile_read_arbiter_if.sv | 35 +++
 rtl/regfile_read_arbiter.sv | 140 ++++++++++++++
 tb/tb_regfile_read_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_read_arbiter_if
//   Requester-side bundle for the register-file read arbiter.
//   req_valid  : requester i has a read pending
//   req_addr   : register number requested by requester i (5 bits each)
//   req_ready  : requester i is granted this cycle
//   resp_valid : read data for requester i is valid this cycle
//   resp_data  : read result for requester i (64 bits each)
//   master modport = requester side, slave modport = arbiter side.
// ---------------------------------------------------------------------------
interface regfile_read_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0][4:0]   req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [NUM_REQ-1:0][63:0]  resp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output resp_valid,
    output resp_data
  );
endinterface

// File: rtl/regfile_read_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_read_arbiter
//   Shares the register file's two combinational read ports among NUM_REQ
//   requesters. Each cycle up to two pending requests are granted in
//   round-robin order starting at ptr_r; the first gets read port 1, the
//   second read port 2. The read data is captured at the grant edge and
//   returned to each requester one cycle later.
//
//   Ports:
//     clk            system clock, rising edge
//     reset          asynchronous active-high reset
//     bus            requester channel (regfile_read_arbiter_if.slave)
//     readRegister1  register file read select, port 1 (combinational)
//     readRegister2  register file read select, port 2 (combinational)
//     readData1      register file read data, port 1
//     readData2      register file read data, port 2
// ---------------------------------------------------------------------------
module regfile_read_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_read_arbiter_if.slave   bus,
  output logic [4:0]              readRegister1,
  output logic [4:0]              readRegister2,
  input  logic [63:0]             readData1,
  input  logic [63:0]             readData2
);

  logic [PTR_W-1:0]          ptr_r;
  logic [PTR_W-1:0]          ptr_nxt_s;
  logic [PTR_W-1:0]          g1_idx_s;
  logic [PTR_W-1:0]          g2_idx_s;
  logic                      g1_found_s;
  logic                      g2_found_s;
  logic [NUM_REQ-1:0]        req_ready_s;
  logic [4:0]                rd_sel1_s;
  logic [4:0]                rd_sel2_s;
  logic [NUM_REQ-1:0]        resp_valid_r;
  logic [NUM_REQ-1:0][63:0]  resp_data_r;

  // Next pointer position after idx, wrapping at NUM_REQ (which need not be a power of two).
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
    if (idx == PTR_W'(NUM_REQ - 1)) begin
      wrap_inc = {PTR_W{1'b0}};
    end else begin
      wrap_inc = idx + PTR_W'(1);
    end
  endfunction

  // Round-robin scan from ptr_r: first valid index is g1, next valid one is g2.
  always_comb begin
    logic [PTR_W:0]   sum_v;
    logic [PTR_W-1:0] idx_v;
    logic             take1_v;
    logic             take2_v;
    sum_v      = {(PTR_W+1){1'b0}};
    idx_v      = {PTR_W{1'b0}};
    take1_v    = 1'b0;
    take2_v    = 1'b0;
    g1_found_s = 1'b0;
    g2_found_s = 1'b0;
    g1_idx_s   = {PTR_W{1'b0}};
    g2_idx_s   = {PTR_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr_r + k spans at most 2*NUM_REQ-2, so one conditional subtract wraps it.
      sum_v   = {1'b0, ptr_r} + (PTR_W+1)'(k);
      idx_v   = (sum_v >= (PTR_W+1)'(NUM_REQ)) ? PTR_W'(sum_v - (PTR_W+1)'(NUM_REQ))
                                                : PTR_W'(sum_v);
      // take2 is evaluated against the g1 state before this index can claim g1,
      // so a single requester can never land on both ports.
      take1_v    = bus.req_valid[idx_v] & ~g1_found_s;
      take2_v    = bus.req_valid[idx_v] & g1_found_s & ~g2_found_s;
      g1_idx_s   = take1_v ? idx_v : g1_idx_s;
      g2_idx_s   = take2_v ? idx_v : g2_idx_s;
      g1_found_s = g1_found_s | take1_v;
      g2_found_s = g2_found_s | take2_v;
    end
  end

  // Grant strobes and read selects; everything is forced idle while reset is high.
  always_comb begin
    req_ready_s = {NUM_REQ{1'b0}};
    rd_sel1_s   = 5'd0;
    rd_sel2_s   = 5'd0;
    if (!reset && g1_found_s) begin
      req_ready_s[g1_idx_s] = 1'b1;
      rd_sel1_s             = bus.req_addr[g1_idx_s];
    end else begin
      rd_sel1_s             = 5'd0;
    end
    if (!reset && g2_found_s) begin
      req_ready_s[g2_idx_s] = 1'b1;
      rd_sel2_s             = bus.req_addr[g2_idx_s];
    end else begin
      rd_sel2_s             = 5'd0;
    end
  end

  // Pointer moves just past the last granted requester; holds when idle.
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (g2_found_s) begin
      ptr_nxt_s = wrap_inc(g2_idx_s);
    end else if (g1_found_s) begin
      ptr_nxt_s = wrap_inc(g1_idx_s);
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Pointer, response strobes and captured read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r        <= {PTR_W{1'b0}};
      resp_valid_r <= {NUM_REQ{1'b0}};
      resp_data_r  <= {(NUM_REQ*64){1'b0}};
    end else begin
      ptr_r        <= ptr_nxt_s;
      resp_valid_r <= req_ready_s;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (g1_found_s && (g1_idx_s == PTR_W'(i))) begin
          resp_data_r[i] <= readData1;
        end else if (g2_found_s && (g2_idx_s == PTR_W'(i))) begin
          resp_data_r[i] <= readData2;
        end else begin
          resp_data_r[i] <= resp_data_r[i];
        end
      end
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_data  = resp_data_r;
  assign readRegister1  = rd_sel1_s;
  assign readRegister2  = rd_sel2_s;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_read_arbiter
//   Self-checking bench: a round-robin reference model predicts grants and
//   read selects each cycle, pushes the expected responses into a scoreboard
//   queue, and the queue is drained against resp_valid/resp_data one cycle
//   later. Directed scenarios add fixed expected values.
// ---------------------------------------------------------------------------
module tb_regfile_read_arbiter;

  localparam int NUM_REQ = 4;

  typedef struct {
    int          idx;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  readRegister1;
  logic [4:0]  readRegister2;
  logic [63:0] readData1;
  logic [63:0] readData2;
  logic [63:0] rf [32];

  exp_t sb[$];
  int   ptr_m;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  regfile_read_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  regfile_read_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .readRegister1 (readRegister1),
    .readRegister2 (readRegister2),
    .readData1     (readData1),
    .readData2     (readData2)
  );

  always #5 clk = ~clk;

  // combinational register file model
  assign readData1 = rf[readRegister1];
  assign readData2 = rf[readRegister2];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drain the scoreboard against the registered response outputs
  task automatic check_resp();
    logic [3:0] exp_v;
    exp_t       e;
    exp_v = 4'b0000;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      exp_v[e.idx] = 1'b1;
      check_val($sformatf("resp_data[%0d]", e.idx), bus.resp_data[e.idx], e.data);
    end
    check_val("resp_valid", 64'(bus.resp_valid), 64'(exp_v));
  endtask

  // one arbitration cycle: starts and ends just after a falling edge
  task automatic cycle(input logic [3:0] v, input logic [3:0][4:0] a,
                       output logic [3:0] rdy, output logic [4:0] r1, output logic [4:0] r2);
    int         g[$];
    logic [3:0] exp_rdy;
    logic [4:0] e1;
    logic [4:0] e2;
    exp_t       e;
    bus.req_valid = v;
    bus.req_addr  = a;
    #1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (ptr_m + k) % NUM_REQ;
      if (v[i] && g.size() < 2) g.push_back(i);
    end
    exp_rdy = 4'b0000;
    e1      = 5'd0;
    e2      = 5'd0;
    if (g.size() > 0) begin
      exp_rdy[g[0]] = 1'b1;
      e1     = a[g[0]];
      e.idx  = g[0];
      e.data = rf[e1];
      sb.push_back(e);
    end
    if (g.size() > 1) begin
      exp_rdy[g[1]] = 1'b1;
      e2     = a[g[1]];
      e.idx  = g[1];
      e.data = rf[e2];
      sb.push_back(e);
    end
    rdy = bus.req_ready;
    r1  = readRegister1;
    r2  = readRegister2;
    check_val("req_ready", 64'(rdy), 64'(exp_rdy));
    check_val("readRegister1", 64'(r1), 64'(e1));
    check_val("readRegister2", 64'(r2), 64'(e2));
    @(posedge clk);
    if (g.size() > 0) ptr_m = (g[g.size()-1] + 1) % NUM_REQ;
    @(negedge clk);
    check_resp();
  endtask

  initial begin
    logic [3:0]      rdy;
    logic [4:0]      r1;
    logic [4:0]      r2;
    logic [3:0][4:0] ra;
    logic [3:0][4:0] all_a;

    for (int r = 0; r < 32; r++) rf[r] = 64'hC0DE_0000_0000_0000 | 64'(r);
    rf[5] = 64'h0000_0000_DEAD_BEEF;
    rf[2] = 64'h22;
    rf[7] = 64'h77;
    rf[9] = 64'h99;
    rf[1] = 64'h11;
    rf[4] = 64'h44;
    all_a = {5'd13, 5'd12, 5'd11, 5'd10};

    // reset at power-up with requests pending: no grants, selects idle
    reset         = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_addr  = all_a;
    ptr_m         = 0;
    #1;
    check_val("rst_ready", 64'(bus.req_ready), 64'd0);
    check_val("rst_rr1", 64'(readRegister1), 64'd0);
    check_val("rst_rr2", 64'(readRegister2), 64'd0);
    @(negedge clk);
    reset         = 1'b0;
    bus.req_valid = 4'b0000;
    check_val("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    for (int i = 0; i < NUM_REQ; i++)
      check_val($sformatf("rst_resp_data[%0d]", i), bus.resp_data[i], 64'd0);

    // dual grant from ptr=0: requesters 0 and 3
    cycle(4'b1001, {5'd7, 5'd0, 5'd0, 5'd2}, rdy, r1, r2);
    check_val("dual_ready", 64'(rdy), 64'b1001);
    check_val("dual_rr1", 64'(r1), 64'd2);
    check_val("dual_rr2", 64'(r2), 64'd7);
    check_val("dual_data0", bus.resp_data[0], 64'h22);
    check_val("dual_data3", bus.resp_data[3], 64'h77);

    // single request: requester 1, addr 5
    cycle(4'b0010, {5'd0, 5'd0, 5'd5, 5'd0}, rdy, r1, r2);
    check_val("single_ready", 64'(rdy), 64'b0010);
    check_val("single_rr1", 64'(r1), 64'd5);
    check_val("single_rr2", 64'(r2), 64'd0);
    check_val("single_valid", 64'(bus.resp_valid), 64'b0010);
    check_val("single_data", bus.resp_data[1], 64'h0000_0000_DEAD_BEEF);

    // bring ptr back to 0 (grant 3 alone from ptr=2), then fairness run
    cycle(4'b1000, all_a, rdy, r1, r2);
    cycle(4'b1111, all_a, rdy, r1, r2);
    check_val("fair_0", 64'(rdy), 64'b0011);
    cycle(4'b1111, all_a, rdy, r1, r2);
    check_val("fair_1", 64'(rdy), 64'b1100);
    cycle(4'b1111, all_a, rdy, r1, r2);
    check_val("fair_2", 64'(rdy), 64'b0011);
    cycle(4'b1111, all_a, rdy, r1, r2);
    check_val("fair_3", 64'(rdy), 64'b1100);

    // ptr back at 0 -> requester 2 alone moves it to 3; then wrap grants {3,0}
    cycle(4'b0100, all_a, rdy, r1, r2);
    check_val("ptr0_single", 64'(r1), 64'd12);
    cycle(4'b1111, all_a, rdy, r1, r2);
    check_val("wrap_ready", 64'(rdy), 64'b1001);
    check_val("wrap_rr1", 64'(r1), 64'd13);
    check_val("wrap_rr2", 64'(r2), 64'd10);

    // same address on both ports
    cycle(4'b0110, {5'd0, 5'd9, 5'd9, 5'd0}, rdy, r1, r2);
    check_val("same_ready", 64'(rdy), 64'b0110);
    check_val("same_data1", bus.resp_data[1], 64'h99);
    check_val("same_data2", bus.resp_data[2], 64'h99);

    // idle cycles: nothing granted, nothing returned, data held
    for (int c = 0; c < 3; c++) cycle(4'b0000, all_a, rdy, r1, r2);
    check_val("idle_hold_data1", bus.resp_data[1], 64'h99);

    // back-to-back from requester 2 (ptr=3 so it lands on port 1)
    cycle(4'b0100, {5'd0, 5'd1, 5'd0, 5'd0}, rdy, r1, r2);
    check_val("b2b_rr1", 64'(r1), 64'd1);
    check_val("b2b_data_a", bus.resp_data[2], 64'h11);
    cycle(4'b0100, {5'd0, 5'd4, 5'd0, 5'd0}, rdy, r1, r2);
    check_val("b2b_valid", 64'(bus.resp_valid), 64'b0100);
    check_val("b2b_data_b", bus.resp_data[2], 64'h44);

    // reset mid-operation while resp_valid[2] is high
    cycle(4'b0100, all_a, rdy, r1, r2);
    check_val("pre_rst_valid", 64'(bus.resp_valid), 64'b0100);
    bus.req_valid = 4'b1111;
    reset = 1'b1;
    #1;
    check_val("mid_rst_valid", 64'(bus.resp_valid), 64'd0);
    check_val("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    check_val("mid_rst_rr1", 64'(readRegister1), 64'd0);
    check_val("mid_rst_rr2", 64'(readRegister2), 64'd0);
    check_val("mid_rst_data2", bus.resp_data[2], 64'd0);
    sb.delete();
    ptr_m = 0;
    @(negedge clk);
    reset = 1'b0;
    cycle(4'b1111, all_a, rdy, r1, r2);
    check_val("post_rst_ready", 64'(rdy), 64'b0011);

    // random traffic against the model
    for (int c = 0; c < 60; c++) begin
      for (int k = 0; k < NUM_REQ; k++) ra[k] = 5'($urandom_range(0, 31));
      cycle(4'($urandom_range(0, 15)), ra, rdy, r1, r2);
    end
    cycle(4'b0000, all_a, rdy, r1, r2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
